// File: rtl/alu_issue_pkg.sv
// Shared ALU definitions: opcode encodings, operand-select encodings and issue FSM states.
package alu_defs;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00010,
        ALU_SLT  = 5'b00100,
        ALU_SLTU = 5'b00101,
        ALU_AND  = 5'b01001,
        ALU_OR   = 5'b01010,
        ALU_XOR  = 5'b01011,
        ALU_SLL  = 5'b01110,
        ALU_SRL  = 5'b01111,
        ALU_SRA  = 5'b10000,
        ALU_SRC0 = 5'b10001,
        ALU_SRC1 = 5'b10010
    } alu_op_e;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_IMM = 1'b1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } issue_state_e;

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Per-source operand bypass: EX result, then MEM writeback, then register file.
// Also flags a load-use hazard when the EX producer is a load.
module fwd_mux #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs,
    input  logic [XLEN-1:0]    rf_data,
    input  logic               used,
    input  logic               ex_wen,
    input  logic               ex_is_load,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_res,
    input  logic               mem_wen,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_wdata,
    output logic [XLEN-1:0]    data,
    output logic               load_hazard
);

    logic ex_match;
    logic mem_match;

    always_comb begin
        ex_match    = ex_wen && (ex_rd == rs);
        mem_match   = mem_wen && (mem_rd == rs);
        load_hazard = used && ex_match && ex_is_load && (ex_rd != '0);

        // A load in EX never forwards; the stall lets MEM supply it next cycle.
        if (rs == '0)
            data = '0;
        else if (ex_match && !ex_is_load)
            data = ex_res;
        else if (mem_match)
            data = mem_wdata;
        else
            data = rf_data;
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: operand select/forwarding, load-use stall, valid/ready
// handshake with hold and flush, registered operands for EX.
module alu_issue
    import alu_defs::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_op,
    input  logic               in_sel0,
    input  logic               in_sel1,
    input  logic [RADDR_W-1:0] in_rs0,
    input  logic [RADDR_W-1:0] in_rs1,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_wen,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    rf_rdata0,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic               ex_wen,
    input  logic               ex_is_load,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_res,
    input  logic               mem_wen,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_src0,
    output logic [XLEN-1:0]    alu_src1,
    output logic [4:0]         alu_op,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_wen
);

    issue_state_e     state;
    logic [XLEN-1:0]  fwd0;
    logic [XLEN-1:0]  fwd1;
    logic             haz0;
    logic             haz1;
    logic             hazard;
    logic             transfer;

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd0 (
        .rs          (in_rs0),
        .rf_data     (rf_rdata0),
        .used        (in_sel0 == SEL_REG),
        .ex_wen      (ex_wen),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_res      (ex_res),
        .mem_wen     (mem_wen),
        .mem_rd      (mem_rd),
        .mem_wdata   (mem_wdata),
        .data        (fwd0),
        .load_hazard (haz0)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd1 (
        .rs          (in_rs1),
        .rf_data     (rf_rdata1),
        .used        (in_sel1 == SEL_REG),
        .ex_wen      (ex_wen),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_res      (ex_res),
        .mem_wen     (mem_wen),
        .mem_rd      (mem_rd),
        .mem_wdata   (mem_wdata),
        .data        (fwd1),
        .load_hazard (haz1)
    );

    // HOLD implies out_valid, so the same ready term covers both states.
    always_comb begin
        hazard   = haz0 || haz1;
        in_ready = !flush && !hazard &&
                   ((state == ST_RUN) ? (!out_valid || out_ready) : out_ready);
        transfer = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            alu_src0  <= '0;
            alu_src1  <= '0;
            alu_op    <= ALU_ADD;
            out_rd    <= '0;
            out_wen   <= 1'b0;
        end else if (flush) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
        end else if (transfer) begin
            state     <= ST_RUN;
            out_valid <= 1'b1;
            alu_src0  <= (in_sel0 == SEL_PC)  ? in_pc  : fwd0;
            alu_src1  <= (in_sel1 == SEL_IMM) ? in_imm : fwd1;
            alu_op    <= in_op;
            out_rd    <= in_rd;
            out_wen   <= in_wen;
        end else if (out_valid && out_ready) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
        end else if (out_valid) begin
            state     <= ST_HOLD;
        end
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage on the producer side of the ALU operand interface: accepts decoded instructions, selects and forwards operands, and registers alu_src0, alu_src1 and alu_op for the EX stage.
- Resolves RAW hazards by forwarding from the EX and MEM stages, and by inserting a one-cycle load-use stall.
- Uses a valid/ready handshake on both sides and supports flush.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard the in-flight and held instruction
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  issue stage can accept an instruction
- in_op  in  5  ALU opcode (shared encoding)
- in_sel0  in  1  src0 select: 0 = rs0 data, 1 = pc
- in_sel1  in  1  src1 select: 0 = rs1 data, 1 = imm
- in_rs0, in_rs1  in  RADDR_W  source register addresses
- in_rd  in  RADDR_W  destination register
- in_wen  in  1  instruction writes rd
- in_pc, in_imm  in  XLEN  pc and immediate
- rf_rdata0, rf_rdata1  in  XLEN  register-file read data (same cycle as in_rs*)
- ex_wen, ex_is_load  in  1  EX-stage write enable and load flag
- ex_rd  in  RADDR_W  EX-stage destination
- ex_res  in  XLEN  EX-stage ALU result
- mem_wen  in  1  MEM-stage write enable
- mem_rd  in  RADDR_W  MEM-stage destination
- mem_wdata  in  XLEN  MEM-stage writeback data
- out_valid  out  1  operands valid for ALU
- out_ready  in  1  EX stage accepts
- alu_src0, alu_src1  out  XLEN  registered ALU operands
- alu_op  out  5  registered opcode
- out_rd  out  RADDR_W  registered destination
- out_wen  out  1  registered write enable

Behaviour:
- Reset (async, rst=1): out_valid=0, alu_src0=alu_src1=0, alu_op=ADD (00000), out_rd=0, out_wen=0, state=RUN.
- Clock is clk. Reset is rst: asynchronous, active-high. All outputs are registered except in_ready.
- Operand forwarding (combinational, per source, only when the corresponding sel=0):
  - Priority: EX (ex_wen & ex_rd==rs & ~ex_is_load) > MEM (mem_wen & mem_rd==rs) > rf_rdata.
  - rs==0 always yields 0, never forwarded.
- Load-use hazard: ex_is_load & ex_wen & ex_rd!=0 & ex_rd equals a used source (sel=0).
  - in_ready=0.
  - If out_ready, issue a bubble (out_valid=0).
  - In the next cycle, the operand is taken from MEM forwarding.
- State machine:
  - RUN: in_ready = ~hazard & (~out_valid | out_ready).
    - Transfer occurs on in_valid & in_ready.
    - On transfer, the output regs load the selected operands and out_valid becomes 1.
    - If out_valid & out_ready and there is no transfer, out_valid becomes 0.
  - HOLD: entered when out_valid & ~out_ready.
    - Outputs are frozen and in_ready=0.
    - Returns to RUN the cycle out_ready=1 (that cycle can accept a new instruction if there is no hazard).
- Latency: 1 cycle from accepted input to out_valid.
- Sustained throughput: 1 instruction per cycle with no hazard and out_ready=1.
- Flush:
  - Next edge: out_valid=0, out_wen=0, state=RUN.
  - Input in the same cycle is dropped; in_ready is forced to 0 during flush.
  - Flush overrides hazard and HOLD.
- Simultaneous EX and MEM match on the same rs: EX wins unless it is a load.
- A load match triggers the stall, not MEM forwarding of stale data.
- Width: all operands are XLEN; no arithmetic is performed in this block.

Decomposition:
- Shared package alu_defs:
  - ALU opcode constants: ADD 00000, SUB 00010, SLT 00100, SLTU 00101, AND 01001, OR 01010, XOR 01011, SLL 01110, SRL 01111, SRA 10000, SRC0 10001, SRC1 10010.
  - SEL_REG/SEL_PC and SEL_REG/SEL_IMM select encodings.
- One sub-module fwd_mux (instantiated twice): rs, rf data, EX/MEM bypass inputs -> forwarded operand plus a load-hazard flag.

Test Plan:
- Plain issue: rf_rdata0=5, rf_rdata1=7, op=ADD, no bypass, out_ready=1 -> next cycle out_valid=1, alu_src0=5, alu_src1=7, alu_op=00000.
- Forward priority: rs0=3, ex_wen=1, ex_rd=3, ex_res=0xAA, mem_wen=1, mem_rd=3, mem_wdata=0xBB -> alu_src0=0xAA. Drop ex_wen -> alu_src0=0xBB. Set rs0=0 -> alu_src0=0.
- Load-use: ex_is_load=1, ex_rd=4, rs1=4, sel1=0 -> in_ready=0 and one bubble (out_valid=0). Next cycle mem_rd=4, mem_wdata=0x1234 -> issue with alu_src1=0x1234. With sel1=1 (imm) -> no stall.
- Back-pressure: out_ready=0 for 3 cycles with valid output -> outputs stable, in_ready=0. On out_ready=1, the pending new instruction issues the following cycle with no loss or duplication.
- Flush: assert flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not issued.
- Async reset mid-stream: rst=1 between clock edges -> outputs clear immediately to reset values. Release, then issue sel0=1, pc=0x1C000000, sel1=1, imm=0x10 -> alu_src0=0x1C000000, alu_src1=0x10.
